ofdm_interval_timer: RTL

Loadable down-counting interval timer that opens a gating window of a programmed length and reports expiry with a one-cycle terminal pulse. It drives the enable side of the baseband counter chain: it asserts `window` for exactly the programmed number of cycles, which serves as a counter/stage enable, then signals `tc`. The transmit sequencer uses it for symbol, cyclic-prefix and guard-interval pacing.

---
 rtl/ofdm_interval_timer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/ofdm_interval_timer.sv
// ofdm_interval_timer
//
// Loadable down-counting interval timer. A start opens a gating window that
// lasts exactly the programmed number of cycles (window = stage enable for
// the baseband counter chain), followed by a single-cycle terminal pulse tc.
// Used by the transmit sequencer for symbol / cyclic-prefix / guard pacing.
//
// Optional feature: define OFDM_TIMER_AUTO_RELOAD_EN to add the `periodic`
// input, which restarts the interval from DONE without needing `start`.
//
// Ports:
//   clk       in   single clock, rising edge
//   rst       in   asynchronous, active-low reset
//   load      in   write load_val into the period register (IDLE/DONE only)
//   load_val  in   [COUNT_WIDTH] new period in cycles
//   start     in   begin one interval
//   abort     in   cancel the interval immediately (highest priority)
//   periodic  in   auto-reload request (only with OFDM_TIMER_AUTO_RELOAD_EN)
//   count     out  [COUNT_WIDTH] remaining cycles in the window
//   busy      out  state is not IDLE
//   window    out  high exactly while in RUN
//   tc        out  one-cycle expiry pulse, high in DONE
module ofdm_interval_timer #(
  parameter int COUNT_WIDTH  = 4,
  parameter int DEFAULT_LOAD = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [COUNT_WIDTH-1:0] load_val,
  input  logic                   start,
  input  logic                   abort,
`ifdef OFDM_TIMER_AUTO_RELOAD_EN
  input  logic                   periodic,
`endif
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   busy,
  output logic                   window,
  output logic                   tc
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] RESET_PERIOD = COUNT_WIDTH'(DEFAULT_LOAD);
  localparam logic [COUNT_WIDTH-1:0] ONE          = COUNT_WIDTH'(1);

  state_t                   state_q,  state_d;
  logic [COUNT_WIDTH-1:0]   count_q,  count_d;
  logic [COUNT_WIDTH-1:0]   period_q, period_d;

  logic [COUNT_WIDTH-1:0]   eff_period;
  logic                     reload_req;

`ifdef OFDM_TIMER_AUTO_RELOAD_EN
  assign reload_req = periodic;
`else
  assign reload_req = 1'b0;
`endif

  // A same-cycle load overrides the stored period for the interval it launches.
  assign eff_period = load ? load_val : period_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    period_d = period_q;

    // The period register is frozen while an interval is running; a load that
    // coincides with abort outside RUN still lands.
    if (load && (state_q != S_RUN)) begin
      period_d = load_val;
    end

    if (abort) begin
      state_d = S_IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            // A zero period skips RUN entirely so window never pulses.
            if (eff_period == '0) begin
              state_d = S_DONE;
              count_d = '0;
            end else begin
              state_d = S_RUN;
              count_d = eff_period;
            end
          end
        end
        S_RUN: begin
          // count is never 0 in RUN; the <= guard keeps it from wrapping anyway.
          if (count_q <= ONE) begin
            state_d = S_DONE;
            count_d = '0;
          end else begin
            count_d = count_q - ONE;
          end
        end
        S_DONE: begin
          if (start || reload_req) begin
            if (eff_period == '0) begin
              state_d = S_DONE;
              count_d = '0;
            end else begin
              state_d = S_RUN;
              count_d = eff_period;
            end
          end else begin
            state_d = S_IDLE;
            count_d = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      period_q <= RESET_PERIOD;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      period_q <= period_d;
    end
  end

  // All outputs come straight from registers: no input-to-output paths.
  assign count  = count_q;
  assign busy   = (state_q != S_IDLE);
  assign window = (state_q == S_RUN);
  assign tc     = (state_q == S_DONE);

endmodule
